// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// alu_ctrl_pkg: shared state type, default sizing and one-hot helper
// Rev 1.0
// ----------------------------------------------------------------------
package alu_ctrl_pkg;

  localparam int C_N_UNITS_DEF     = 4;
  localparam int C_SEL_W_DEF       = 2;
  localparam int C_TIMEOUT_CYC_DEF = 15;
  localparam int C_CNT_W_DEF       = 4;
  localparam int C_MAX_UNITS       = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Out-of-range indices encode to all-zero rather than wrapping.
  function automatic logic [C_MAX_UNITS-1:0] onehot_encode(input int unsigned idx);
    logic [C_MAX_UNITS-1:0] v;
    v = '0;
    if (idx < C_MAX_UNITS) v[idx[3:0]] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_unit_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// alu_unit_sequencer_if: command handshake and execution-unit bus
// Rev 1.0
// ----------------------------------------------------------------------
interface alu_unit_sequencer_if
  import alu_ctrl_pkg::*;
#(
  parameter int N_UNITS = C_N_UNITS_DEF,
  parameter int SEL_W   = C_SEL_W_DEF
);
  logic [SEL_W-1:0]   ALU_FUN;
  logic               FUN_VALID;
  logic               FUN_READY;
  logic [N_UNITS-1:0] UNIT_DONE;
  logic [N_UNITS-1:0] UNIT_ENABLE;
  logic [SEL_W-1:0]   ACTIVE_UNIT;
  logic               OUT_VALID;
  logic               ILLEGAL_FUN;
  logic               TIMEOUT;

  modport master (
    output ALU_FUN, FUN_VALID, UNIT_DONE,
    input  FUN_READY, UNIT_ENABLE, ACTIVE_UNIT, OUT_VALID, ILLEGAL_FUN, TIMEOUT
  );

  modport slave (
    input  ALU_FUN, FUN_VALID, UNIT_DONE,
    output FUN_READY, UNIT_ENABLE, ACTIVE_UNIT, OUT_VALID, ILLEGAL_FUN, TIMEOUT
  );
endinterface
`default_nettype wire

// File: rtl/fun_onehot_dec.sv
`default_nettype none
// ----------------------------------------------------------------------
// fun_onehot_dec: unit index to one-hot enable plus legality flag
// Rev 1.0
// ----------------------------------------------------------------------
module fun_onehot_dec
  import alu_ctrl_pkg::*;
#(
  parameter int N_UNITS = C_N_UNITS_DEF,
  parameter int SEL_W   = C_SEL_W_DEF
) (
  input  logic [SEL_W-1:0]   i_idx,
  output logic [N_UNITS-1:0] o_onehot,
  output logic               o_legal
);

  always_comb begin
    o_legal  = (32'(i_idx) < N_UNITS);
    o_onehot = o_legal ? N_UNITS'(onehot_encode(32'(i_idx))) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/alu_unit_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------
// alu_unit_sequencer: handshake-driven one-hot unit enable with watchdog
// Rev 1.0
// ----------------------------------------------------------------------
module alu_unit_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int N_UNITS     = C_N_UNITS_DEF,
  parameter int SEL_W       = C_SEL_W_DEF,
  parameter int TIMEOUT_CYC = C_TIMEOUT_CYC_DEF,
  parameter int CNT_W       = C_CNT_W_DEF
) (
  input logic                 CLK,
  input logic                 RST,
  alu_unit_sequencer_if.slave bus
);

  state_t             r_state;
  logic               r_ready;
  logic [N_UNITS-1:0] r_enable;
  logic [SEL_W-1:0]   r_active;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_valid;
  logic               r_illegal;
  logic               r_timeout;

  state_t             w_state_nxt;
  logic [SEL_W-1:0]   w_active_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_out_valid_nxt;
  logic               w_illegal_nxt;
  logic               w_timeout_nxt;
  logic               w_xfer;
  logic               w_done;
  logic               w_expire;
  logic [SEL_W-1:0]   w_dec_idx;
  logic [N_UNITS-1:0] w_dec_onehot;
  logic               w_dec_legal;

  // Decode the incoming code while idle so the enable can register on the
  // transfer edge itself; once busy the latched index keeps it stable.
  assign w_dec_idx = (r_state == IDLE) ? bus.ALU_FUN : r_active;

  fun_onehot_dec #(
    .N_UNITS (N_UNITS),
    .SEL_W   (SEL_W)
  ) u_dec (
    .i_idx    (w_dec_idx),
    .o_onehot (w_dec_onehot),
    .o_legal  (w_dec_legal)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_active_nxt    = r_active;
    w_cnt_nxt       = r_cnt;
    w_out_valid_nxt = 1'b0;
    w_illegal_nxt   = 1'b0;
    w_timeout_nxt   = 1'b0;
    w_xfer          = bus.FUN_VALID && r_ready;
    // Masking with the one-hot enable honours only the active unit's done.
    w_done          = |(bus.UNIT_DONE & r_enable);
    w_cnt_inc       = r_cnt + CNT_W'(1);
    w_expire        = (w_cnt_inc == CNT_W'(TIMEOUT_CYC));

    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          if (w_dec_legal) begin
            w_state_nxt  = BUSY;
            w_active_nxt = bus.ALU_FUN;
            w_cnt_nxt    = '0;
          end else begin
            w_illegal_nxt = 1'b1;
          end
        end
      end
      BUSY: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_done) begin
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = IDLE;
        end else if (w_expire) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_ready     <= 1'b0;
      r_enable    <= '0;
      r_active    <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ready     <= (w_state_nxt == IDLE);
      r_enable    <= (w_state_nxt == BUSY) ? w_dec_onehot : '0;
      r_active    <= w_active_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_illegal   <= w_illegal_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign bus.FUN_READY   = r_ready;
  assign bus.UNIT_ENABLE = r_enable;
  assign bus.ACTIVE_UNIT = r_active;
  assign bus.OUT_VALID   = r_out_valid;
  assign bus.ILLEGAL_FUN = r_illegal;
  assign bus.TIMEOUT     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_alu_unit_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_alu_unit_sequencer: scoreboard bench for 4-unit and 3-unit sequencers
// Rev 1.0
// ----------------------------------------------------------------------
module tb_alu_unit_sequencer;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  alu_unit_sequencer_if #(.N_UNITS(4), .SEL_W(2)) bus4 ();
  alu_unit_sequencer_if #(.N_UNITS(3), .SEL_W(2)) bus3 ();

  alu_unit_sequencer #(.N_UNITS(4), .SEL_W(2), .TIMEOUT_CYC(15), .CNT_W(4)) dut4 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus4)
  );

  alu_unit_sequencer #(.N_UNITS(3), .SEL_W(2), .TIMEOUT_CYC(15), .CNT_W(4)) dut3 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus3)
  );

  // kind: 0 = OUT_VALID, 1 = TIMEOUT, 2 = ILLEGAL_FUN, 3 = OUT_VALID and TIMEOUT, -1 = none
  typedef struct {
    int kind;
    int unit;
    int en_cyc;
    logic [3:0] en_vec;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Issue one request to the 4-unit DUT from a negedge with FUN_READY=1 and
  // run until a completion pulse appears; returns at that pulse's negedge.
  task automatic op4(input int fun, input int noise_at, input logic [3:0] noise_vec,
                     input int done_at, input logic [3:0] done_vec,
                     output int en_cyc, output int kind, output int unit,
                     output int cyc, output logic [3:0] seen, output bit multi);
    en_cyc = 0; kind = -1; unit = -1; cyc = 0; seen = '0; multi = 1'b0;
    bus4.ALU_FUN   = 2'(fun);
    bus4.FUN_VALID = 1'b1;
    for (int c = 0; c < 40 && kind < 0; c++) begin
      @(negedge CLK);
      cyc            = c + 1;
      bus4.FUN_VALID = 1'b0;
      bus4.UNIT_DONE = '0;
      if (bus4.OUT_VALID && bus4.TIMEOUT) kind = 3;
      else if (bus4.OUT_VALID)           kind = 0;
      else if (bus4.TIMEOUT)             kind = 1;
      else if (bus4.ILLEGAL_FUN)         kind = 2;
      if (kind >= 0) unit = int'(bus4.ACTIVE_UNIT);
      if (bus4.UNIT_ENABLE != '0) begin
        en_cyc++;
        seen = seen | bus4.UNIT_ENABLE;
        if ($countones(bus4.UNIT_ENABLE) != 1) multi = 1'b1;
        if (en_cyc == noise_at) bus4.UNIT_DONE = noise_vec;
        if (en_cyc == done_at)  bus4.UNIT_DONE = done_vec;
      end
    end
    bus4.UNIT_DONE = '0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    bus4.ALU_FUN = '0; bus4.FUN_VALID = 1'b0; bus4.UNIT_DONE = '0;
    bus3.ALU_FUN = '0; bus3.FUN_VALID = 1'b0; bus3.UNIT_DONE = '0;
    repeat (2) @(negedge CLK);
    checks++;
    if (bus4.FUN_READY !== 1'b0 || bus3.FUN_READY !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b/%b want 0/0", bus4.FUN_READY, bus3.FUN_READY);
    end
    checks++;
    if ({bus4.UNIT_ENABLE, bus4.ACTIVE_UNIT, bus4.OUT_VALID, bus4.ILLEGAL_FUN, bus4.TIMEOUT} !== 9'h0) begin
      errors++; $display("FAIL reset_outputs: got en=%b act=%0d pulses=%b%b%b want all 0",
                         bus4.UNIT_ENABLE, bus4.ACTIVE_UNIT, bus4.OUT_VALID, bus4.ILLEGAL_FUN, bus4.TIMEOUT);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (bus4.FUN_READY !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge: got %b want 0", bus4.FUN_READY);
    end
    @(negedge CLK);
    checks++;
    if (bus4.FUN_READY !== 1'b1 || bus3.FUN_READY !== 1'b1) begin
      errors++; $display("FAIL ready_after_release: got %b/%b want 1/1", bus4.FUN_READY, bus3.FUN_READY);
    end
    checks++;
    if ({bus4.UNIT_ENABLE, bus4.OUT_VALID, bus4.ILLEGAL_FUN, bus4.TIMEOUT} !== 7'h0) begin
      errors++; $display("FAIL idle_outputs: got en=%b pulses=%b%b%b want 0",
                         bus4.UNIT_ENABLE, bus4.OUT_VALID, bus4.ILLEGAL_FUN, bus4.TIMEOUT);
    end
  endtask

  // Pop one expectation and compare it against an observed operation.
  task automatic test_op(input string name, input int fun, input int noise_at, input logic [3:0] noise_vec,
                         input int done_at, input logic [3:0] done_vec);
    int en_cyc, kind, unit, cyc;
    logic [3:0] seen;
    bit multi;
    exp_t e;
    op4(fun, noise_at, noise_vec, done_at, done_vec, en_cyc, kind, unit, cyc, seen, multi);
    e = sb_q.pop_front();
    checks++;
    if (kind != e.kind) begin
      errors++; $display("FAIL %s_kind: got %0d want %0d", name, kind, e.kind);
    end
    checks++;
    if (unit != e.unit) begin
      errors++; $display("FAIL %s_active_unit: got %0d want %0d", name, unit, e.unit);
    end
    checks++;
    if (en_cyc != e.en_cyc || cyc != e.en_cyc + 1) begin
      errors++; $display("FAIL %s_enable_cycles: got %0d (op %0d) want %0d (op %0d)",
                         name, en_cyc, cyc, e.en_cyc, e.en_cyc + 1);
    end
    checks++;
    if (seen !== e.en_vec || multi) begin
      errors++; $display("FAIL %s_enable_vec: got %b multi=%b want %b", name, seen, multi, e.en_vec);
    end
    checks++;
    if (bus4.UNIT_ENABLE !== 4'b0 || bus4.FUN_READY !== 1'b1) begin
      errors++; $display("FAIL %s_end_state: got en=%b ready=%b want 0000/1", name, bus4.UNIT_ENABLE, bus4.FUN_READY);
    end
  endtask

  task automatic test_done();
    sb_q.push_back('{kind: 0, unit: 2, en_cyc: 3, en_vec: 4'b0100});
    test_op("done", 2, 0, 4'b0, 3, 4'b0100);
    @(negedge CLK);
    checks++;
    if (bus4.OUT_VALID !== 1'b0 || bus4.TIMEOUT !== 1'b0) begin
      errors++; $display("FAIL done_pulse_width: got ov=%b to=%b want 0/0", bus4.OUT_VALID, bus4.TIMEOUT);
    end
  endtask

  task automatic test_timeout();
    sb_q.push_back('{kind: 1, unit: 3, en_cyc: 15, en_vec: 4'b1000});
    test_op("timeout", 3, 0, 4'b0, 0, 4'b0);
    @(negedge CLK);
    checks++;
    if (bus4.TIMEOUT !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse_width: got %b want 0", bus4.TIMEOUT);
    end
    sb_q.push_back('{kind: 0, unit: 0, en_cyc: 15, en_vec: 4'b0001});
    test_op("done_wins", 0, 0, 4'b0, 15, 4'b0001);
  endtask

  task automatic test_wrong_units();
    sb_q.push_back('{kind: 0, unit: 1, en_cyc: 5, en_vec: 4'b0010});
    test_op("wrong_units", 1, 2, 4'b1001, 5, 4'b0010);
  endtask

  task automatic test_back_to_back();
    sb_q.push_back('{kind: 0, unit: 1, en_cyc: 1, en_vec: 4'b0010});
    sb_q.push_back('{kind: 0, unit: 3, en_cyc: 1, en_vec: 4'b1000});
    test_op("b2b_first", 1, 0, 4'b0, 1, 4'b0010);
    test_op("b2b_second", 3, 0, 4'b0, 1, 4'b1000);
  endtask

  task automatic test_illegal();
    int k;
    exp_t e;
    sb_q.push_back('{kind: 2, unit: 0, en_cyc: 0, en_vec: 4'b0});
    sb_q.push_back('{kind: 2, unit: 0, en_cyc: 0, en_vec: 4'b0});
    sb_q.push_back('{kind: 0, unit: 0, en_cyc: 1, en_vec: 4'b0001});
    bus3.ALU_FUN = 2'd3; bus3.FUN_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (i == 1) bus3.ALU_FUN = 2'd0;
      if (i == 2) begin
        bus3.FUN_VALID = 1'b0;
        checks++;
        if (bus3.UNIT_ENABLE !== 3'b001 || bus3.ACTIVE_UNIT !== 2'd0 || bus3.ILLEGAL_FUN !== 1'b0) begin
          errors++; $display("FAIL legal_after_illegal: got en=%b act=%0d ill=%b want 001/0/0",
                             bus3.UNIT_ENABLE, bus3.ACTIVE_UNIT, bus3.ILLEGAL_FUN);
        end
        bus3.UNIT_DONE = 3'b001;
        @(negedge CLK);
        bus3.UNIT_DONE = 3'b000;
      end
      k = bus3.OUT_VALID ? 0 : (bus3.ILLEGAL_FUN ? 2 : (bus3.TIMEOUT ? 1 : -1));
      e = sb_q.pop_front();
      checks++;
      if (k != e.kind) begin
        errors++; $display("FAIL illegal_seq_%0d: got kind %0d want %0d", i, k, e.kind);
      end
      checks++;
      if (bus3.UNIT_ENABLE !== 3'b000 || bus3.FUN_READY !== 1'b1) begin
        errors++; $display("FAIL illegal_idle_%0d: got en=%b ready=%b want 000/1", i, bus3.UNIT_ENABLE, bus3.FUN_READY);
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    int pulses;
    bus4.ALU_FUN = 2'd2; bus4.FUN_VALID = 1'b1;
    @(negedge CLK);
    bus4.FUN_VALID = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus4.UNIT_ENABLE !== 4'b0100) begin
      errors++; $display("FAIL rst_busy_pre: got %b want 0100", bus4.UNIT_ENABLE);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if (bus4.UNIT_ENABLE !== 4'b0 || bus4.FUN_READY !== 1'b0 || bus4.ACTIVE_UNIT !== 2'd0) begin
      errors++; $display("FAIL rst_async: got en=%b ready=%b act=%0d want 0000/0/0",
                         bus4.UNIT_ENABLE, bus4.FUN_READY, bus4.ACTIVE_UNIT);
    end
    @(negedge CLK);
    RST = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (bus4.OUT_VALID || bus4.TIMEOUT || bus4.UNIT_ENABLE != 4'b0) pulses++;
    end
    checks++;
    if (pulses != 0 || bus4.FUN_READY !== 1'b1) begin
      errors++; $display("FAIL rst_no_pulse: got %0d activity cycles ready=%b want 0/1", pulses, bus4.FUN_READY);
    end
  endtask

  initial begin
    test_reset();
    test_done();
    test_timeout();
    test_wrong_units();
    test_back_to_back();
    test_illegal();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
`default_nettype wire
